// File: rtl/sseg_event_display.sv
// Event queue feeding the seven-segment peripheral's alternate-input path.
// Each queued event is shown for a fixed hold time, with optional blink and leading-zero blanking.
module sseg_event_display #(
    parameter int unsigned HOLD_CYCLES  = 50_000_000,
    parameter int unsigned BLINK_CYCLES = 12_500_000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ev_valid,
    input  logic [31:0] i_ev_data,
    input  logic [1:0]  i_ev_kind,
    output logic        o_ev_ready,
    input  logic        i_flush,
    output logic [31:0] o_alt_data,
    output logic [5:0]  o_alt_en,
    output logic        o_alt_sel,
    output logic        o_busy
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES);
    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
    } ev_t;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t          state_q, state_d;
    ev_t             mem_q [FIFO_DEPTH];
    ev_t             mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic            phase_q, phase_d;
    logic            blink_en_q, blink_en_d;
    logic [5:0]      mask_q, mask_d;
    logic [31:0]     data_q, data_d;
    logic [5:0]      en_q, en_d;
    logic            sel_q, sel_d;
    logic            busy_q, busy_d;

    logic            full;
    logic            push;
    logic            pop;
    logic            hold_done;
    ev_t             head;

    // Digit k stays lit if it is digit 0 or any nibble at or above it is nonzero.
    function automatic logic [5:0] lz_mask(input logic [23:0] d);
        logic [5:0] m;
        m[5] = |d[23:20];
        for (int k = 4; k >= 0; k--) begin
            m[k] = m[k+1] | (|d[4*k +: 4]);
        end
        m[0] = 1'b1;
        return m;
    endfunction

    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign o_ev_ready = i_reset && !full && !i_flush;
    assign push       = i_ev_valid && o_ev_ready;
    assign hold_done  = (hold_q == HW'(HOLD_CYCLES - 1));
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        hold_d     = hold_q;
        blink_d    = blink_q;
        phase_d    = phase_q;
        blink_en_d = blink_en_q;
        mask_d     = mask_q;
        data_d     = data_q;
        en_d       = en_q;
        sel_d      = sel_q;
        pop        = 1'b0;

        if (i_flush) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            hold_d   = '0;
            blink_d  = '0;
            sel_d    = 1'b0;
            en_d     = 6'h00;
        end else begin
            pop = (count_q != '0) && ((state_q == IDLE) || hold_done);
            if (push) begin
                mem_d[wr_ptr_q] = '{kind: i_ev_kind, data: i_ev_data};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);

            if (pop) begin
                state_d    = SHOW;
                sel_d      = 1'b1;
                data_d     = head.data;
                mask_d     = head.kind[1] ? lz_mask(head.data[23:0]) : 6'h3F;
                en_d       = mask_d;
                blink_en_d = head.kind[0];
                phase_d    = 1'b1;
                hold_d     = '0;
                blink_d    = '0;
            end else if (state_q == SHOW) begin
                if (hold_done) begin
                    state_d = IDLE;
                    sel_d   = 1'b0;
                    en_d    = 6'h00;
                    hold_d  = '0;
                    blink_d = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                    // Blink phase flips after every BLINK_CYCLES cycles of display.
                    if (blink_en_q) begin
                        if (blink_q == BW'(BLINK_CYCLES - 1)) begin
                            blink_d = '0;
                            phase_d = !phase_q;
                            en_d    = phase_d ? mask_q : 6'h00;
                        end else begin
                            blink_d = blink_q + BW'(1);
                        end
                    end
                end
            end
        end

        busy_d = (state_d == SHOW) || (count_d != '0);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            blink_q    <= '0;
            phase_q    <= 1'b0;
            blink_en_q <= 1'b0;
            mask_q     <= 6'h00;
            data_q     <= '0;
            en_q       <= 6'h00;
            sel_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            blink_q    <= blink_d;
            phase_q    <= phase_d;
            blink_en_q <= blink_en_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            en_q       <= en_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_alt_data = data_q;
    assign o_alt_en   = en_q;
    assign o_alt_sel  = sel_q;
    assign o_busy     = busy_q;

endmodule

// File: doc/sseg_event_display.md
# sseg_event_display

Upstream driver for the seven-segment Wishbone peripheral's alternate-input path: it queues 32-bit status events (halt PC, exception codes, debug values) and drives the peripheral's alternate data, enable and select inputs. Each event is shown for a fixed hold time, with optional blinking and leading-zero blanking. When no event is pending, it releases the display back to the software-written Wishbone value.

## Interface
- HOLD_CYCLES, 50_000_000: cycles each event stays displayed (>= 2)
- BLINK_CYCLES, 12_500_000: cycles per blink half-period (>= 1)
- FIFO_DEPTH, 4: event queue entries; power of two, >= 2

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  reset; one clock; reset is synchronous and active-low (0 = reset)
- i_ev_valid  in  1  event offered
- i_ev_data  in  32  event value
- i_ev_kind  in  2  bit0 = blink, bit1 = blank leading zeros
- o_ev_ready  out  1  combinational: i_reset && !full && !i_flush
- i_flush  in  1  drop queue and current event, release display
- o_alt_data  out  32  to peripheral alternate data (registered)
- o_alt_en  out  6  to peripheral per-digit enable (registered)
- o_alt_sel  out  1  to peripheral alternate select (registered)
- o_busy  out  1  registered; 1 when state is SHOW or the queue is non-empty

## Operation
- Queue: FIFO of {kind, data}, depth FIFO_DEPTH. Push on i_ev_valid && o_ev_ready. Pop is internal.
- No push when full, even if a pop happens in the same cycle.
- Push and pop in the same cycle on a non-empty, non-full queue are both legal; the count is unchanged.
- States: IDLE, SHOW.
- IDLE, queue non-empty: pop the head, load the display registers, clear the hold and blink counters, go to SHOW.
- IDLE, queue empty: o_alt_sel = 0.
- SHOW: o_alt_sel = 1. The hold counter increments each cycle.
- SHOW, hold counter == HOLD_CYCLES-1, queue non-empty: pop and load the next event on the same edge. Stay in SHOW, with no gap in o_alt_sel.
- SHOW, hold counter == HOLD_CYCLES-1, queue empty: go to IDLE and clear o_alt_sel.
- Display load: o_alt_data = event data. Bits [31:24] are passed through; the peripheral uses [23:0].
- Digit enable mask = bit k set if k == 0 or any nibble j in [k..5] of data[23:0] is nonzero. This mask applies only when kind bit1 = 1; otherwise the mask = 6'h3F.
- Blink (kind bit0 = 1): the phase starts "on" at load and toggles every BLINK_CYCLES cycles. When off, o_alt_en = 6'h00; when on, o_alt_en = the mask.
- Without blink: o_alt_en = the mask for the whole hold.
- i_flush: on the next edge, empty the queue, go to IDLE, o_alt_sel = 0, o_alt_en = 0. o_alt_data holds its last value. Flush overrides pop, load and push.
- Reset (i_reset = 0) takes priority over everything, including mid-SHOW and mid-blink. After the reset edge: queue empty, IDLE, all counters 0.

## Timing
- Reset values: o_alt_data = 0, o_alt_en = 0, o_alt_sel = 0, o_busy = 0. o_ev_ready = 0 while i_reset = 0.
- Latency, event pushed into an empty queue while IDLE:
  - Push at edge N.
  - Pop and load at edge N+1.
  - o_alt_sel, o_alt_data and o_alt_en are valid after edge N+1.
- Hold: o_alt_sel stays 1 for exactly HOLD_CYCLES cycles per event.
- Back-to-back events follow each other with no idle cycle.
- Last event: o_alt_sel falls after the HOLD_CYCLES-th cycle.
- Blink: first toggle BLINK_CYCLES cycles after load, then every BLINK_CYCLES cycles. The blink counter is reset on each load.
- o_ev_ready reflects the queue state after the previous edge; it is never 1 when full.
- All counters are wide enough for their parameter and never wrap within a hold.

## Test plan
1. Reset, then push one event 0x00_0012AB, kind = 0, with HOLD_CYCLES = 8. Required:
   - o_alt_sel = 1, o_alt_data = 0x0012AB, o_alt_en = 6'h3F one edge after the push.
   - o_alt_sel stays 1 for 8 cycles, then returns to 0. o_busy follows the same window.
2. Kind = 2 (blank leading zeros):
   - data 0x000120 -> o_alt_en = 6'h07.
   - data 0x000000 -> o_alt_en = 6'h01.
   - data 0x900000 -> o_alt_en = 6'h3F.
3. Kind = 1, BLINK_CYCLES = 2, HOLD_CYCLES = 8. Required o_alt_en per cycle after load: 3F, 3F, 00, 00, 3F, 3F, 00, 00; then o_alt_sel = 0.
4. Push 5 events back-to-back with FIFO_DEPTH = 4. Required:
   - o_ev_ready drops to 0 once the queue is full.
   - All accepted events display in order with no o_alt_sel gap.
   - A new push is accepted only after the next pop.
5. i_flush mid-SHOW with 2 events queued. Required:
   - Next edge: o_alt_sel = 0, o_alt_en = 0, o_busy = 0.
   - A push held during the flush cycle is not accepted (o_ev_ready = 0).
6. Drive i_reset = 0 mid-blink with the queue non-empty. Required:
   - After that edge, all outputs are at reset values.
   - After release, a new event displays with phase "on".
